upd_llr_user_scheduler: RTL and testbench
=========================================

# upd_llr_user_scheduler

Per-user sequencer for the slow PHY-to-LLR sender. It accepts user descriptors (RE count and IQ/noise rate) and drives the sender's shared state code and configuration through USERSTART/USERSEND. It gates sending on IQ/noise FIFO occupancy, counts consumed REs, and signals per-user and per-batch completion. It sits between the uplink control/descriptor queue and the sender datapath.

## Interface
- NUM_USERS, 8: maximum descriptors per batch; sets o_user_idx width, $clog2(NUM_USERS).
- WDOG_CYCLES, 4096: stall timeout in cycles (used only with the watchdog macro).
- i_core_clk  in  1  core clock.
- i_rx_rstn  in  1  reset, asynchronous, active-low.
- i_batch_start  in  1  single-cycle pulse; arms a batch (ignored unless IDLE).
- i_batch_last  in  1  qualifies a descriptor as the last one in the batch.
- i_user_valid  in  1  descriptor valid.
- o_user_ready  out  1  descriptor ready. Transfer occurs when valid & ready.
- i_user_re_num  in  16  REs for this user.
- i_user_rate  in  16  IQ/noise rate for this user.
- i_iq_fifo_empty  in  1  IQ FIFO empty flag.
- i_noise_fifo_empty  in  1  noise FIFO empty flag.
- i_iq_rd_en  in  1  sender IQ read strobe; each strobe consumes 2 REs.
- o_state  out  3  sender state code (shared package encoding).
- o_user_iq_noise_rate  out  16  latched rate of the current user.
- o_send_en  out  1  high in USERSEND while both FIFOs are non-empty.
- o_rx_fsm_rstn  out  1  active-low sender flush; default 1.
- o_user_done  out  1  1-cycle pulse at user completion.
- o_user_skip  out  1  qualifies o_user_done: user was skipped.
- o_user_idx  out  $clog2(NUM_USERS)  index of the current user in the batch.
- o_batch_done  out  1  1-cycle pulse after the last user completes.
- o_err  out  1  sticky error; cleared only by i_batch_start.

## Operation
- States: IDLE, LOAD, USERSTART, WAITDATA, USERSEND, USERDONE.
- IDLE: on i_batch_start, clear o_user_idx and o_err. o_user_ready=1 only while armed (batch started and last user not yet taken).
- IDLE → LOAD on descriptor handshake.
- LOAD:
  - Latch rate. Target = re_num rounded up to even.
  - If rate==0, rate odd, or re_num==0: set o_err only for the rate cases, then go to USERDONE with o_user_skip=1.
  - Otherwise go to USERSTART.
- USERSTART: lasts exactly 1 cycle; the sender clears its counters.
- WAITDATA → USERSEND when both FIFOs are non-empty.
- USERSEND:
  - re_cnt += 2 on each i_iq_rd_en.
  - When re_cnt+2 >= target on a strobe, go to USERDONE.
  - An i_iq_rd_en while i_iq_fifo_empty=1 sets o_err (underflow); the count still advances.
- USERDONE: lasts 1 cycle; o_user_done pulses.
  - If that user was marked last: pulse o_batch_done and go to IDLE (disarmed).
  - Otherwise o_user_idx++ and go to IDLE (still armed), which accepts the next descriptor.
- A descriptor arriving in any other state is held by ready=0.
- Descriptors beyond NUM_USERS: o_user_idx saturates and o_err is set.

## Timing
- Reset values: state IDLE, o_state=IDLE code, o_user_iq_noise_rate=0, all pulses 0, o_send_en=0, o_rx_fsm_rstn=1, o_user_idx=0, o_err=0, re_cnt=0.
- Handshake at cycle N → LOAD at N+1 → USERSTART at N+2 → WAITDATA at N+3.
- USERSEND is entered 1 cycle after both FIFOs are seen non-empty.
- o_send_en is registered: it follows FIFO flags with 1 cycle of latency and is never high outside USERSEND.
- Final rd_en at cycle M → o_user_done at M+1 → next handshake possible at M+2.
- Reset mid-operation returns all outputs to reset values; i_batch_start in the same cycle as reset is ignored.

## Configuration
- UPD_LLR_WDOG_EN defined:
  - A counter runs in WAITDATA/USERSEND and reloads on each i_iq_rd_en or state change.
  - On reaching WDOG_CYCLES: set o_err, drive o_rx_fsm_rstn low for 2 cycles, then USERDONE with o_user_skip=1.
- UPD_LLR_WDOG_EN undefined: no counter, o_rx_fsm_rstn tied to 1, and a stall persists indefinitely.

## Structure
- Shared package: state enum (3-bit codes, with IDLE=0, USERSTART=2 and USERSEND=4 shared with the sender), RE step constant 2, and the sender rate legality rule.
- One sub-module, upd_llr_wdog (load/expire counter), instantiated only under UPD_LLR_WDOG_EN.

## Test plan
- Descriptor re_num=8, rate=4, FIFOs non-empty, rd_en every other cycle → 4 strobes, o_user_done 1 cycle after the 4th, o_err=0.
- re_num=7 → target 8; done after 4 strobes. re_num=0 → o_user_done with o_user_skip=1 at handshake+2, o_err=0.
- rate=3 → skip, o_err=1; o_err persists until the next i_batch_start.
- Noise FIFO empty for 20 cycles after USERSTART → stays in WAITDATA with o_send_en=0; USERSEND 1 cycle after the flag drops.
- Three descriptors, third with i_batch_last → o_user_idx 0,1,2; single o_batch_done pulse; o_user_ready=0 afterward.
- With UPD_LLR_WDOG_EN and WDOG_CYCLES=16, no rd_en in USERSEND → at cycle 16 o_err=1, o_rx_fsm_rstn low for 2 cycles, then skip-done.

Source files
------------

// File: rtl/upd_llr_user_scheduler_pkg.sv
// Shared definitions for the LLR user scheduler and the sender datapath:
// state codes, RE step per IQ read, and the sender rate legality rule.
package upd_llr_user_scheduler_pkg;

    // IDLE, USERSTART and USERSEND codes are also decoded by the sender.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_USERSTART = 3'd2,
        ST_WAITDATA  = 3'd3,
        ST_USERSEND  = 3'd4,
        ST_USERDONE  = 3'd5
    } state_e;

    // One IQ read strobe carries two REs.
    localparam int unsigned RE_STEP = 2;

    // The sender handles only non-zero, even rates.
    function automatic logic rate_legal(input logic [15:0] rate);
        return (rate != 16'd0) && !rate[0];
    endfunction

    // RE target rounded up to the next even count.
    function automatic logic [16:0] re_target(input logic [15:0] re_num);
        return {1'b0, re_num} + {16'd0, re_num[0]};
    endfunction

endpackage

// File: rtl/upd_llr_wdog.sv
// Stall watchdog: counts while running, reloads on activity, flags expiry.
// Ports: i_core_clk, i_rx_rstn, i_run, i_reload, o_expire. Built only with UPD_LLR_WDOG_EN.
`ifdef UPD_LLR_WDOG_EN
module upd_llr_wdog #(
    parameter int CYCLES = 4096
) (
    input  logic i_core_clk,
    input  logic i_rx_rstn,
    input  logic i_run,
    input  logic i_reload,
    output logic o_expire
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_run || i_reload) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign o_expire = i_run && !i_reload && (cnt_q == LAST);

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/upd_llr_user_scheduler.sv
// Per-user sequencer for the slow PHY-to-LLR sender: takes user descriptors,
// drives sender state/rate, gates sending on FIFO occupancy, counts REs.
// Ports: i_core_clk/i_rx_rstn; batch arm (i_batch_start) and descriptor
// handshake (i_user_valid/o_user_ready, i_user_re_num, i_user_rate,
// i_batch_last); FIFO flags and i_iq_rd_en from the sender; outputs o_state,
// o_user_iq_noise_rate, o_send_en, o_rx_fsm_rstn, o_user_done/o_user_skip,
// o_user_idx, o_batch_done, sticky o_err.
// Optional stall watchdog: define UPD_LLR_WDOG_EN.
module upd_llr_user_scheduler
    import upd_llr_user_scheduler_pkg::*;
#(
    parameter int NUM_USERS = 8
`ifdef UPD_LLR_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 4096
`endif
) (
    input  logic                         i_core_clk,
    input  logic                         i_rx_rstn,
    input  logic                         i_batch_start,
    input  logic                         i_batch_last,
    input  logic                         i_user_valid,
    output logic                         o_user_ready,
    input  logic [15:0]                  i_user_re_num,
    input  logic [15:0]                  i_user_rate,
    input  logic                         i_iq_fifo_empty,
    input  logic                         i_noise_fifo_empty,
    input  logic                         i_iq_rd_en,
    output logic [2:0]                   o_state,
    output logic [15:0]                  o_user_iq_noise_rate,
    output logic                         o_send_en,
    output logic                         o_rx_fsm_rstn,
    output logic                         o_user_done,
    output logic                         o_user_skip,
    output logic [$clog2(NUM_USERS)-1:0] o_user_idx,
    output logic                         o_batch_done,
    output logic                         o_err
);

    localparam int IDX_W = $clog2(NUM_USERS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_USERS - 1);

    state_e             state_q, state_d;
    logic [15:0]        rate_q, rate_d;
    logic [16:0]        target_q, target_d;
    logic [16:0]        re_cnt_q, re_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic               armed_q, armed_d;
    logic               last_q, last_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         flush_q, flush_d;
    logic               user_done_q, user_done_d;
    logic               skip_q, skip_d;
    logic               batch_done_q, batch_done_d;
    logic               send_en_q, send_en_d;

    logic               hs;
    logic               fifo_ok;
    logic [16:0]        re_next;
    logic               wdog_expire;

    assign o_user_ready = (state_q == ST_IDLE) && armed_q;
    assign hs           = i_user_valid && o_user_ready;
    assign fifo_ok      = !i_iq_fifo_empty && !i_noise_fifo_empty;
    assign re_next      = re_cnt_q + 17'(RE_STEP);

`ifdef UPD_LLR_WDOG_EN
    logic enter_q;
    logic rx_rstn_q;
    logic wdog_run;

    assign wdog_run = ((state_q == ST_WAITDATA) || (state_q == ST_USERSEND))
                   && (flush_q == 2'd0);

    upd_llr_wdog #(
        .CYCLES   (WDOG_CYCLES)
    ) u_wdog (
        .i_core_clk (i_core_clk),
        .i_rx_rstn  (i_rx_rstn),
        .i_run      (wdog_run),
        .i_reload   (i_iq_rd_en || enter_q),
        .o_expire   (wdog_expire)
    );

    // enter_q reloads the watchdog on the first cycle of each new state.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            enter_q   <= 1'b0;
            rx_rstn_q <= 1'b1;
        end else begin
            enter_q   <= (state_d != state_q);
            rx_rstn_q <= (flush_d == 2'd0);
        end
    end

    assign o_rx_fsm_rstn = rx_rstn_q;
`else
    assign wdog_expire   = 1'b0;
    assign o_rx_fsm_rstn = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        rate_d       = rate_q;
        target_d     = target_q;
        re_cnt_d     = re_cnt_q;
        idx_d        = idx_q;
        err_d        = err_q;
        armed_d      = armed_q;
        last_d       = last_q;
        ovf_d        = ovf_q;
        flush_d      = flush_q;
        user_done_d  = 1'b0;
        skip_d       = 1'b0;
        batch_done_d = 1'b0;

        if (flush_q != 2'd0) begin
            // Sender flush in progress; finish the user as skipped.
            flush_d = flush_q - 2'd1;
            if (flush_q == 2'd1) begin
                state_d     = ST_USERDONE;
                user_done_d = 1'b1;
                skip_d      = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_batch_start) begin
                        armed_d = 1'b1;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                    if (hs) begin
                        rate_d   = i_user_rate;
                        target_d = re_target(i_user_re_num);
                        last_d   = i_batch_last;
                        if (i_batch_last) armed_d = 1'b0;
                        // Index already saturated: this descriptor overflows.
                        if (ovf_q) err_d = 1'b1;
                        state_d  = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    re_cnt_d = '0;
                    if (!rate_legal(rate_q) || (target_q == 17'd0)) begin
                        if (!rate_legal(rate_q)) err_d = 1'b1;
                        state_d     = ST_USERDONE;
                        user_done_d = 1'b1;
                        skip_d      = 1'b1;
                    end else begin
                        state_d = ST_USERSTART;
                    end
                end
                ST_USERSTART: begin
                    re_cnt_d = '0;
                    state_d  = ST_WAITDATA;
                end
                ST_WAITDATA: begin
                    if (wdog_expire) begin
                        err_d   = 1'b1;
                        flush_d = 2'd2;
                    end else if (fifo_ok) begin
                        state_d = ST_USERSEND;
                    end
                end
                ST_USERSEND: begin
                    if (wdog_expire) begin
                        err_d   = 1'b1;
                        flush_d = 2'd2;
                    end else if (i_iq_rd_en) begin
                        re_cnt_d = re_next;
                        if (i_iq_fifo_empty) err_d = 1'b1;
                        if (re_next >= target_q) begin
                            state_d     = ST_USERDONE;
                            user_done_d = 1'b1;
                        end
                    end
                end
                ST_USERDONE: begin
                    state_d = ST_IDLE;
                    if (last_q) begin
                        batch_done_d = 1'b1;
                    end else if (idx_q == IDX_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        send_en_d = (state_d == ST_USERSEND) && fifo_ok && (flush_d == 2'd0);
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q      <= ST_IDLE;
            rate_q       <= '0;
            target_q     <= '0;
            re_cnt_q     <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            armed_q      <= 1'b0;
            last_q       <= 1'b0;
            ovf_q        <= 1'b0;
            flush_q      <= '0;
            user_done_q  <= 1'b0;
            skip_q       <= 1'b0;
            batch_done_q <= 1'b0;
            send_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_q       <= rate_d;
            target_q     <= target_d;
            re_cnt_q     <= re_cnt_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            armed_q      <= armed_d;
            last_q       <= last_d;
            ovf_q        <= ovf_d;
            flush_q      <= flush_d;
            user_done_q  <= user_done_d;
            skip_q       <= skip_d;
            batch_done_q <= batch_done_d;
            send_en_q    <= send_en_d;
        end
    end

    assign o_state              = state_q;
    assign o_user_iq_noise_rate = rate_q;
    assign o_send_en            = send_en_q;
    assign o_user_done          = user_done_q;
    assign o_user_skip          = skip_q;
    assign o_user_idx           = idx_q;
    assign o_batch_done         = batch_done_q;
    assign o_err                = err_q;

endmodule

// File: tb/tb_upd_llr_user_scheduler.sv
// Testbench for upd_llr_user_scheduler (default build, watchdog disabled).
// Reference outcomes come from per-user rules: skip/err/strobe-count/latency.
module tb_upd_llr_user_scheduler;

    logic        clk;
    logic        i_rx_rstn;
    logic        i_batch_start;
    logic        i_batch_last;
    logic        i_user_valid;
    logic        o_user_ready;
    logic [15:0] i_user_re_num;
    logic [15:0] i_user_rate;
    logic        i_iq_fifo_empty;
    logic        i_noise_fifo_empty;
    logic        i_iq_rd_en;
    logic [2:0]  o_state;
    logic [15:0] o_user_iq_noise_rate;
    logic        o_send_en;
    logic        o_rx_fsm_rstn;
    logic        o_user_done;
    logic        o_user_skip;
    logic [2:0]  o_user_idx;
    logic        o_batch_done;
    logic        o_err;

    int errors = 0;
    int checks = 0;

    upd_llr_user_scheduler #(.NUM_USERS(8)) dut (
        .i_core_clk           (clk),
        .i_rx_rstn            (i_rx_rstn),
        .i_batch_start        (i_batch_start),
        .i_batch_last         (i_batch_last),
        .i_user_valid         (i_user_valid),
        .o_user_ready         (o_user_ready),
        .i_user_re_num        (i_user_re_num),
        .i_user_rate          (i_user_rate),
        .i_iq_fifo_empty      (i_iq_fifo_empty),
        .i_noise_fifo_empty   (i_noise_fifo_empty),
        .i_iq_rd_en           (i_iq_rd_en),
        .o_state              (o_state),
        .o_user_iq_noise_rate (o_user_iq_noise_rate),
        .o_send_en            (o_send_en),
        .o_rx_fsm_rstn        (o_rx_fsm_rstn),
        .o_user_done          (o_user_done),
        .o_user_skip          (o_user_skip),
        .o_user_idx           (o_user_idx),
        .o_batch_done         (o_batch_done),
        .o_err                (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rx_rstn          = 1'b0;
        i_batch_start      = 1'b0;
        i_batch_last       = 1'b0;
        i_user_valid       = 1'b0;
        i_user_re_num      = '0;
        i_user_rate        = '0;
        i_iq_fifo_empty    = 1'b0;
        i_noise_fifo_empty = 1'b0;
        i_iq_rd_en         = 1'b0;
        repeat (3) tick();
        i_rx_rstn = 1'b1;
        tick();
    endtask

    task automatic start_batch();
        i_batch_start = 1'b1;
        tick();
        i_batch_start = 1'b0;
    endtask

    // Offers one descriptor and plays a sender that strobes only while
    // o_send_en is high and the IQ FIFO is non-empty, at least gap idle
    // cycles apart. Edge 0 is the handshake edge; returns edge numbers of
    // the last strobe and of the observed o_user_done.
    task automatic run_user(input int re, input int rate, input bit last,
                            input int gap, input bit rnd,
                            output int ns, output int le, output int de,
                            output bit sk, output bit ok);
        int t;
        int cd;
        ns = 0; le = -1; de = -1; sk = 1'b0; ok = 1'b0;
        t = 0;
        while (!o_user_ready && t < 50) begin
            tick();
            t++;
        end
        if (!o_user_ready) return;
        i_user_valid  = 1'b1;
        i_user_re_num = 16'(re);
        i_user_rate   = 16'(rate);
        i_batch_last  = last;
        tick();
        i_user_valid = 1'b0;
        i_batch_last = 1'b0;
        cd = gap;
        for (int e = 1; e <= 400; e++) begin
            if (rnd) begin
                i_iq_fifo_empty    = ($urandom_range(0, 3) == 0);
                i_noise_fifo_empty = ($urandom_range(0, 3) == 0);
            end
            i_iq_rd_en = o_send_en && !i_iq_fifo_empty && (cd >= gap);
            tick();
            if (i_iq_rd_en) begin
                ns++;
                le = e;
                cd = 0;
            end else begin
                cd++;
            end
            if (o_user_done) begin
                de = e;
                sk = o_user_skip;
                ok = 1'b1;
                break;
            end
        end
        i_iq_rd_en         = 1'b0;
        i_iq_fifo_empty    = 1'b0;
        i_noise_fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_state !== 3'd0 || o_user_iq_noise_rate !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d rate=%0d want 0 0", o_state, o_user_iq_noise_rate);
        end
        checks++;
        if (o_send_en !== 1'b0 || o_rx_fsm_rstn !== 1'b1) begin
            errors++;
            $display("FAIL reset_send: send_en=%b rstn=%b want 0 1", o_send_en, o_rx_fsm_rstn);
        end
        checks++;
        if (o_user_done !== 1'b0 || o_user_skip !== 1'b0 || o_batch_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: done=%b skip=%b bdone=%b want 0", o_user_done, o_user_skip, o_batch_done);
        end
        checks++;
        if (o_user_idx !== 3'd0 || o_err !== 1'b0 || o_user_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_misc: idx=%0d err=%b ready=%b want 0 0 0", o_user_idx, o_err, o_user_ready);
        end
    endtask

    task automatic test_basic();
        int ns, le, de;
        bit sk, ok;
        start_batch();
        run_user(8, 4, 1'b1, 1, 1'b0, ns, le, de, sk, ok);
        checks++;
        if (!ok || ns !== 4 || de !== 10 || le !== 10) begin
            errors++;
            $display("FAIL basic_timing: ok=%b strobes=%0d done_edge=%0d last=%0d want 1 4 10 10", ok, ns, de, le);
        end
        checks++;
        if (sk !== 1'b0 || o_err !== 1'b0 || o_user_iq_noise_rate !== 16'd4) begin
            errors++;
            $display("FAIL basic_flags: skip=%b err=%b rate=%0d want 0 0 4", sk, o_err, o_user_iq_noise_rate);
        end
        tick();
        checks++;
        if (o_batch_done !== 1'b1 || o_user_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_bdone: bdone=%b ready=%b want 1 0", o_batch_done, o_user_ready);
        end
    endtask

    task automatic test_odd_zero();
        int ns, le, de;
        bit sk, ok;
        start_batch();
        run_user(7, 2, 1'b0, 0, 1'b0, ns, le, de, sk, ok);
        checks++;
        if (!ok || ns !== 4 || de !== le || sk !== 1'b0) begin
            errors++;
            $display("FAIL odd_re: ok=%b strobes=%0d done=%0d last=%0d skip=%b want 4 strobes", ok, ns, de, le, sk);
        end
        run_user(0, 6, 1'b1, 0, 1'b0, ns, le, de, sk, ok);
        checks++;
        if (!ok || de !== 1 || sk !== 1'b1 || ns !== 0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_re: ok=%b done_edge=%0d skip=%b strobes=%0d err=%b want 1 1 1 0 0", ok, de, sk, ns, o_err);
        end
        tick();
    endtask

    task automatic test_bad_rate();
        int ns, le, de;
        bit sk, ok;
        start_batch();
        run_user(8, 3, 1'b0, 0, 1'b0, ns, le, de, sk, ok);
        checks++;
        if (!ok || de !== 1 || sk !== 1'b1 || o_err !== 1'b1) begin
            errors++;
            $display("FAIL rate_odd: ok=%b done_edge=%0d skip=%b err=%b want 1 1 1 1", ok, de, sk, o_err);
        end
        run_user(4, 2, 1'b0, 0, 1'b0, ns, le, de, sk, ok);
        checks++;
        if (!ok || sk !== 1'b0 || o_err !== 1'b1 || o_user_idx !== 3'd1) begin
            errors++;
            $display("FAIL err_sticky: ok=%b skip=%b err=%b idx=%0d want 1 0 1 1", ok, sk, o_err, o_user_idx);
        end
        run_user(4, 0, 1'b1, 0, 1'b0, ns, le, de, sk, ok);
        checks++;
        if (!ok || sk !== 1'b1 || o_err !== 1'b1) begin
            errors++;
            $display("FAIL rate_zero: ok=%b skip=%b err=%b want 1 1 1", ok, sk, o_err);
        end
        tick();
        tick();
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold_idle: err=%b want 1", o_err);
        end
        start_batch();
        checks++;
        if (o_err !== 1'b0 || o_user_idx !== 3'd0 || o_user_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%b idx=%0d ready=%b want 0 0 1", o_err, o_user_idx, o_user_ready);
        end
        run_user(0, 2, 1'b1, 0, 1'b0, ns, le, de, sk, ok);
        tick();
    endtask

    task automatic test_fifo_stall();
        int ns;
        bit done;
        start_batch();
        i_noise_fifo_empty = 1'b1;
        i_user_valid  = 1'b1;
        i_user_re_num = 16'd4;
        i_user_rate   = 16'd2;
        i_batch_last  = 1'b1;
        tick();
        i_user_valid = 1'b0;
        i_batch_last = 1'b0;
        tick();
        checks++;
        if (o_state !== 3'd2) begin
            errors++;
            $display("FAIL userstart_code: state=%0d want 2", o_state);
        end
        for (int e = 2; e <= 21; e++) begin
            tick();
            checks++;
            if (o_state === 3'd4 || o_send_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_edge%0d: state=%0d send_en=%b want not 4, 0", e, o_state, o_send_en);
            end
        end
        i_noise_fifo_empty = 1'b0;
        tick();
        checks++;
        if (o_state !== 3'd4 || o_send_en !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: state=%0d send_en=%b want 4 1", o_state, o_send_en);
        end
        ns = 0;
        done = 1'b0;
        for (int e = 0; e < 10 && !done; e++) begin
            i_iq_rd_en = 1'b1;
            tick();
            ns++;
            done = o_user_done;
        end
        i_iq_rd_en = 1'b0;
        checks++;
        if (!done || ns !== 2 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_finish: done=%b strobes=%0d err=%b want 1 2 0", done, ns, o_err);
        end
        tick();
    endtask

    task automatic test_underflow();
        start_batch();
        i_user_valid  = 1'b1;
        i_user_re_num = 16'd4;
        i_user_rate   = 16'd8;
        i_batch_last  = 1'b1;
        tick();
        i_user_valid = 1'b0;
        i_batch_last = 1'b0;
        repeat (3) tick();
        i_iq_fifo_empty = 1'b1;
        i_iq_rd_en      = 1'b1;
        tick();
        checks++;
        if (o_err !== 1'b1 || o_user_done !== 1'b0) begin
            errors++;
            $display("FAIL underflow_err: err=%b done=%b want 1 0", o_err, o_user_done);
        end
        i_iq_fifo_empty = 1'b0;
        tick();
        i_iq_rd_en = 1'b0;
        checks++;
        if (o_user_done !== 1'b1 || o_user_skip !== 1'b0) begin
            errors++;
            $display("FAIL underflow_count: done=%b skip=%b want 1 0", o_user_done, o_user_skip);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int ns, le, de;
        bit sk, ok;
        int bd;
        start_batch();
        for (int u = 0; u < 3; u++) begin
            run_user(2 + 2 * u, 2, u == 2, 0, 1'b0, ns, le, de, sk, ok);
            checks++;
            if (!ok || o_user_idx !== 3'(u) || ns !== u + 1) begin
                errors++;
                $display("FAIL b2b_user%0d: ok=%b idx=%0d strobes=%0d want idx %0d strobes %0d", u, ok, o_user_idx, ns, u, u + 1);
            end
            if (u == 0) begin
                tick();
                checks++;
                if (o_user_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready: ready=%b want 1 two cycles after last strobe", o_user_ready);
                end
            end
        end
        bd = 0;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (o_batch_done) bd++;
        end
        checks++;
        if (bd !== 1 || o_user_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bdone: pulses=%0d ready=%b want 1 0", bd, o_user_ready);
        end
    endtask

    task automatic test_overflow();
        int ns, le, de;
        bit sk, ok;
        start_batch();
        for (int u = 0; u < 8; u++) begin
            run_user(0, 2, 1'b0, 0, 1'b0, ns, le, de, sk, ok);
        end
        checks++;
        if (o_user_idx !== 3'd7 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_eighth: idx=%0d err=%b want 7 0", o_user_idx, o_err);
        end
        run_user(0, 2, 1'b1, 0, 1'b0, ns, le, de, sk, ok);
        checks++;
        if (!ok || o_user_idx !== 3'd7 || o_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_ninth: ok=%b idx=%0d err=%b want 1 7 1", ok, o_user_idx, o_err);
        end
        tick();
    endtask

    task automatic test_random();
        int ns, le, de, nu, re, rate, gap;
        bit sk, ok, legal, skip_exp, err_m;
        logic [2:0] idx_exp;
        int rates[7] = '{0, 2, 3, 4, 6, 8, 5};
        for (int b = 0; b < 4; b++) begin
            start_batch();
            idx_exp = 3'd0;
            err_m   = 1'b0;
            nu      = $urandom_range(2, 4);
            for (int u = 0; u < nu; u++) begin
                re       = $urandom_range(0, 24);
                rate     = rates[$urandom_range(0, 6)];
                gap      = $urandom_range(0, 3);
                legal    = (rate != 0) && (rate % 2 == 0);
                skip_exp = !legal || (re == 0);
                if (!legal) err_m = 1'b1;
                run_user(re, rate, u == nu - 1, gap, 1'b1, ns, le, de, sk, ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL rand_done b%0d u%0d: no o_user_done within budget", b, u);
                    continue;
                end
                checks++;
                if (sk !== skip_exp) begin
                    errors++;
                    $display("FAIL rand_skip b%0d u%0d: skip=%b want %b (re=%0d rate=%0d)", b, u, sk, skip_exp, re, rate);
                end
                checks++;
                if (skip_exp) begin
                    if (de !== 1 || ns !== 0) begin
                        errors++;
                        $display("FAIL rand_skip_lat b%0d u%0d: edge=%0d strobes=%0d want 1 0", b, u, de, ns);
                    end
                end else if (ns !== (re + 1) / 2 || de !== le) begin
                    errors++;
                    $display("FAIL rand_count b%0d u%0d: strobes=%0d done=%0d last=%0d want %0d strobes", b, u, ns, de, le, (re + 1) / 2);
                end
                checks++;
                if (o_user_idx !== idx_exp || o_err !== err_m) begin
                    errors++;
                    $display("FAIL rand_idx_err b%0d u%0d: idx=%0d err=%b want %0d %b", b, u, o_user_idx, o_err, idx_exp, err_m);
                end
                checks++;
                if (o_user_iq_noise_rate !== 16'(rate)) begin
                    errors++;
                    $display("FAIL rand_rate b%0d u%0d: rate=%0d want %0d", b, u, o_user_iq_noise_rate, rate);
                end
                idx_exp++;
            end
            tick();
            checks++;
            if (o_batch_done !== 1'b1 || o_user_ready !== 1'b0) begin
                errors++;
                $display("FAIL rand_bdone b%0d: bdone=%b ready=%b want 1 0", b, o_batch_done, o_user_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_batch();
        i_user_valid  = 1'b1;
        i_user_re_num = 16'd20;
        i_user_rate   = 16'd6;
        tick();
        i_user_valid = 1'b0;
        repeat (3) tick();
        i_iq_rd_en = 1'b1;
        tick();
        i_iq_rd_en    = 1'b0;
        i_rx_rstn     = 1'b0;
        i_batch_start = 1'b1;
        #1;
        checks++;
        if (o_state !== 3'd0 || o_user_iq_noise_rate !== 16'd0 || o_send_en !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out: state=%0d rate=%0d send_en=%b err=%b want 0", o_state, o_user_iq_noise_rate, o_send_en, o_err);
        end
        tick();
        i_rx_rstn     = 1'b1;
        i_batch_start = 1'b0;
        tick();
        checks++;
        if (o_user_ready !== 1'b0 || o_user_idx !== 3'd0 || o_rx_fsm_rstn !== 1'b1) begin
            errors++;
            $display("FAIL midreset_arm: ready=%b idx=%0d rstn=%b want 0 0 1", o_user_ready, o_user_idx, o_rx_fsm_rstn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_zero();
        test_bad_rate();
        test_fifo_stall();
        test_underflow();
        test_back_to_back();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
